ex_stage: RTL and testbench

Execute stage of the 5-stage MIPS pipeline, directly downstream of the decode stage.
- Holds the ID/EX pipeline register and evaluates the 12-op ALU.
- Drives the data SRAM request and produces the EX/MEM bus; the decode stage uses that bus for forwarding.
- Owns the HI/LO registers, a single-cycle MULT/MULTU path and a 32-iteration iterative DIV/DIVU unit, which stalls the pipeline through stallreq_for_ex.

---
 rtl/ex_stage_if.sv | 28 ++
 rtl/ex_stage.sv | 194 +++++++++++++++++++
 tb/tb_ex_stage.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/ex_stage_if.sv
// Execute-stage port bundle: stall vector and decode bus in, EX/MEM bus,
// data SRAM request and divider stall request out.
interface ex_stage_if #(
  parameter int ID_TO_EX_WD  = 159,
  parameter int EX_TO_MEM_WD = 76,
  parameter int STALL_WD     = 6
);
  logic [STALL_WD-1:0]     stall;
  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus;
  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
  logic                    data_sram_en;
  logic [3:0]              data_sram_wen;
  logic [31:0]             data_sram_addr;
  logic [31:0]             data_sram_wdata;
  logic                    stallreq_for_ex;

  modport master (
    output stall, id_to_ex_bus,
    input  ex_to_mem_bus, data_sram_en, data_sram_wen, data_sram_addr,
           data_sram_wdata, stallreq_for_ex
  );

  modport slave (
    input  stall, id_to_ex_bus,
    output ex_to_mem_bus, data_sram_en, data_sram_wen, data_sram_addr,
           data_sram_wdata, stallreq_for_ex
  );
endinterface

// File: rtl/ex_stage.sv
// MIPS execute stage: ID/EX register, 12-op ALU, HI/LO with single-cycle
// multiply and a 32-iteration restoring divider that stalls the front end.
module ex_stage #(
  parameter int ID_TO_EX_WD  = 159,
  parameter int EX_TO_MEM_WD = 76,
  parameter int STALL_WD     = 6
) (
  input logic       clk,
  input logic       rst,
  ex_stage_if.slave bus
);
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [11:0] alu_op;
    logic [2:0]  sel_src1;
    logic [3:0]  sel_src2;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        sel_rf_res;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
  } id_ex_t;

  typedef enum logic [1:0] {DIV_IDLE, DIV_ON, DIV_ZERO, DIV_END} div_st_e;

  logic [STALL_WD-1:0]    stall;
  logic [ID_TO_EX_WD-1:0] ie_q;
  id_ex_t                 ie;
  logic                   ie_load;

  assign stall   = bus.stall;
  assign ie      = ie_q;
  // Any load (instruction or bubble) retires the instruction in EX.
  assign ie_load = ~(stall[2] & stall[3]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      ie_q <= '0;
    else if (stall[2] && !stall[3]) ie_q <= '0;
    else if (!stall[2])             ie_q <= bus.id_to_ex_bus;
  end

  // Local decode of the HI/LO family.
  logic       special;
  logic [5:0] funct;
  logic       is_mult, is_multu, is_div, is_divu, is_mfhi, is_mthi, is_mflo, is_mtlo, div_in_ex;
  assign special   = (ie.inst[31:26] == 6'b000000);
  assign funct     = ie.inst[5:0];
  assign is_mult   = special && funct == 6'b011000;
  assign is_multu  = special && funct == 6'b011001;
  assign is_div    = special && funct == 6'b011010;
  assign is_divu   = special && funct == 6'b011011;
  assign is_mfhi   = special && funct == 6'b010000;
  assign is_mthi   = special && funct == 6'b010001;
  assign is_mflo   = special && funct == 6'b010010;
  assign is_mtlo   = special && funct == 6'b010011;
  assign div_in_ex = is_div | is_divu;

  logic [31:0] src1, src2, alu, result;
  logic [4:0]  shamt;
  assign src1 = ({32{ie.sel_src1[0]}} & ie.rdata1)
              | ({32{ie.sel_src1[1]}} & ie.pc)
              | ({32{ie.sel_src1[2]}} & {27'b0, ie.inst[10:6]});
  assign src2 = ({32{ie.sel_src2[0]}} & ie.rdata2)
              | ({32{ie.sel_src2[1]}} & {{16{ie.inst[15]}}, ie.inst[15:0]})
              | ({32{ie.sel_src2[2]}} & 32'd8)
              | ({32{ie.sel_src2[3]}} & {16'b0, ie.inst[15:0]});
  assign shamt = src1[4:0];

  always_comb begin
    alu = '0;
    if (ie.alu_op[11]) alu |= src1 + src2;
    if (ie.alu_op[10]) alu |= src1 - src2;
    if (ie.alu_op[9])  alu |= {31'b0, $signed(src1) < $signed(src2)};
    if (ie.alu_op[8])  alu |= {31'b0, src1 < src2};
    if (ie.alu_op[7])  alu |= src1 & src2;
    if (ie.alu_op[6])  alu |= ~(src1 | src2);
    if (ie.alu_op[5])  alu |= src1 | src2;
    if (ie.alu_op[4])  alu |= src1 ^ src2;
    if (ie.alu_op[3])  alu |= src2 << shamt;
    if (ie.alu_op[2])  alu |= src2 >> shamt;
    if (ie.alu_op[1])  alu |= 32'($signed(src2) >>> shamt);
    if (ie.alu_op[0])  alu |= {src2[15:0], 16'b0};
  end

  // Divider state.
  div_st_e     state_q, state_d;
  logic [4:0]  cnt_q;
  logic [31:0] dvd_q, dvs_q, rem_q;
  logic        negq_q, negr_q, done_q;
  logic        start, step, fin_zero, fin_end;
  logic [32:0] rsh, diff;

  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    step     = 1'b0;
    fin_zero = 1'b0;
    fin_end  = 1'b0;
    case (state_q)
      DIV_IDLE: if (div_in_ex && !done_q) begin
        start   = 1'b1;
        state_d = (ie.rdata2 == 32'd0) ? DIV_ZERO : DIV_ON;
      end
      DIV_ON: begin
        step = 1'b1;
        if (cnt_q == 5'd31) state_d = DIV_END;
      end
      DIV_ZERO: begin
        fin_zero = 1'b1;
        state_d  = DIV_IDLE;
      end
      default: begin
        fin_end = 1'b1;
        state_d = DIV_IDLE;
      end
    endcase
  end

  assign rsh  = {rem_q, dvd_q[31]};
  assign diff = rsh - {1'b0, dvs_q};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start) begin
        dvd_q  <= (is_div && ie.rdata1[31]) ? -ie.rdata1 : ie.rdata1;
        dvs_q  <= (is_div && ie.rdata2[31]) ? -ie.rdata2 : ie.rdata2;
        rem_q  <= '0;
        cnt_q  <= '0;
        negq_q <= is_div && (ie.rdata1[31] ^ ie.rdata2[31]);
        negr_q <= is_div && ie.rdata1[31];
      end else if (step) begin
        // Restoring step: keep the trial subtraction only if it did not borrow.
        rem_q <= diff[32] ? rsh[31:0] : diff[31:0];
        dvd_q <= {dvd_q[30:0], ~diff[32]};
        cnt_q <= cnt_q + 5'd1;
      end
      if (ie_load)                done_q <= 1'b0;
      else if (fin_zero || fin_end) done_q <= 1'b1;
    end
  end

  logic [31:0] hi_q, lo_q;
  logic [63:0] prod_s, prod_u;
  assign prod_s = {{32{ie.rdata1[31]}}, ie.rdata1} * {{32{ie.rdata2[31]}}, ie.rdata2};
  assign prod_u = {32'b0, ie.rdata1} * {32'b0, ie.rdata2};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (fin_end) begin
      lo_q <= negq_q ? -dvd_q : dvd_q;
      hi_q <= negr_q ? -rem_q : rem_q;
    end else if (fin_zero) begin
      lo_q <= 32'hFFFF_FFFF;
      hi_q <= ie.rdata1;
    end else if (is_mult) begin
      {hi_q, lo_q} <= prod_s;
    end else if (is_multu) begin
      {hi_q, lo_q} <= prod_u;
    end else if (is_mthi) begin
      hi_q <= ie.rdata1;
    end else if (is_mtlo) begin
      lo_q <= ie.rdata1;
    end
  end

  logic [EX_TO_MEM_WD-1:0] mem_bus;
  assign result  = is_mfhi ? hi_q : (is_mflo ? lo_q : alu);
  assign mem_bus = {ie.pc, ie.ram_en, ie.ram_wen, ie.sel_rf_res, ie.rf_we, ie.rf_waddr, result};

  assign bus.ex_to_mem_bus   = mem_bus;
  assign bus.data_sram_en    = ie.ram_en;
  assign bus.data_sram_wen   = ie.ram_wen;
  assign bus.data_sram_addr  = alu;
  assign bus.data_sram_wdata = ie.rdata2;
  assign bus.stallreq_for_ex = div_in_ex & ~done_q & (state_q != DIV_END) & (state_q != DIV_ZERO);

  logic unused_bits;
  assign unused_bits = ^{ie.inst[25:16], stall[5:4], stall[1:0]};
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU, memory request, HI/LO, multiply, divide
// latency and the ID/EX stall/bubble rules, against hand-computed values.
module tb_ex_stage;
  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] ext_stall;
  int         errors = 0;
  int         checks = 0;

  ex_stage_if bus ();
  ex_stage dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  // Stall controller stand-in: a divider request freezes stages 0..3.
  assign bus.stall = bus.stallreq_for_ex ? (ext_stall | 6'b001111) : ext_stall;

  localparam logic [11:0] OP_ADD = 12'h800, OP_SUB = 12'h400, OP_SLT = 12'h200,
                          OP_SLTU = 12'h100, OP_SLL = 12'h008, OP_LUI = 12'h001;

  function automatic logic [158:0] mk(input logic [31:0] pc, inst, input logic [11:0] op,
                                      input logic [2:0] s1, input logic [3:0] s2,
                                      input logic ren, input logic [3:0] wen, input logic we,
                                      input logic [4:0] wa, input logic [31:0] r1, r2);
    return {pc, inst, op, s1, s2, ren, wen, we, wa, 1'b0, r1, r2};
  endfunction

  function automatic logic [31:0] rtype(input logic [5:0] fn);
    return {6'b0, 5'd1, 5'd2, 5'd3, 5'd0, fn};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mf(input logic [5:0] fn);
    bus.id_to_ex_bus = mk(32'h200, rtype(fn), 12'd0, 3'd0, 4'd0, 1'b0, 4'd0, 1'b1, 5'd4, 32'd0, 32'd0);
  endtask

  task automatic run_div(input string tag, input logic [5:0] fn, input logic [31:0] a, b,
                         input int exp_cyc, input logic [31:0] exp_lo, exp_hi);
    int n;
    bus.id_to_ex_bus = mk(32'h100, rtype(fn), 12'd0, 3'd0, 4'd0, 1'b0, 4'd0, 1'b0, 5'd0, a, b);
    tick();
    mf(6'b010010);
    n = 0;
    while (bus.stallreq_for_ex && n < 100) begin
      n++;
      tick();
    end
    chk({tag, "_stall_cycles"}, 64'(n), 64'(exp_cyc));
    tick();
    chk({tag, "_lo"}, 64'(bus.ex_to_mem_bus[31:0]), 64'(exp_lo));
    mf(6'b010000);
    tick();
    chk({tag, "_hi"}, 64'(bus.ex_to_mem_bus[31:0]), 64'(exp_hi));
  endtask

  initial begin
    rst = 1'b1;
    ext_stall = '0;
    bus.id_to_ex_bus = mk(32'h40, {6'b001001, 5'd1, 5'd2, 16'hFFFF}, OP_ADD, 3'b001, 4'b0010,
                          1'b1, 4'hF, 1'b1, 5'd2, 32'd5, 32'h55);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("rst_bus", 64'(bus.ex_to_mem_bus), 64'd0);
    chk("rst_en", 64'(bus.data_sram_en), 64'd0);
    chk("rst_wen", 64'(bus.data_sram_wen), 64'd0);
    chk("rst_addr_wdata", {bus.data_sram_addr, bus.data_sram_wdata}, 64'd0);
    chk("rst_stallreq", 64'(bus.stallreq_for_ex), 64'd0);
    tick();
    rst = 1'b1;
    bus.id_to_ex_bus = '0;
    tick();
    chk("bubble_result", 64'(bus.ex_to_mem_bus[31:0]), 64'd0);
    chk("bubble_rf_we", 64'(bus.ex_to_mem_bus[37]), 64'd0);

    // addiu 5 + (-1)
    bus.id_to_ex_bus = mk(32'h40, {6'b001001, 5'd1, 5'd2, 16'hFFFF}, OP_ADD, 3'b001, 4'b0010,
                          1'b0, 4'd0, 1'b1, 5'd2, 32'd5, 32'd0);
    tick();
    chk("addiu_result", 64'(bus.ex_to_mem_bus[31:0]), 64'd4);
    chk("addiu_rf_we", 64'(bus.ex_to_mem_bus[37]), 64'd1);
    chk("addiu_waddr", 64'(bus.ex_to_mem_bus[36:32]), 64'd2);
    chk("addiu_pc", 64'(bus.ex_to_mem_bus[75:44]), 64'h40);

    // ID/EX hold with stall[2]=stall[3]=1, then bubble with stall[2]=1 only
    ext_stall = 6'b001111;
    bus.id_to_ex_bus = mk(32'h44, rtype(6'b100011), OP_SUB, 3'b001, 4'b0001,
                          1'b0, 4'd0, 1'b1, 5'd3, 32'd3, 32'd5);
    tick();
    chk("hold_result", 64'(bus.ex_to_mem_bus[31:0]), 64'd4);
    ext_stall = 6'b000111;
    tick();
    chk("stall_bubble_bus", 64'(bus.ex_to_mem_bus), 64'd0);
    ext_stall = '0;
    tick();
    chk("subu_result", 64'(bus.ex_to_mem_bus[31:0]), 64'hFFFF_FFFE);

    // sw
    bus.id_to_ex_bus = mk(32'h48, {6'b101011, 5'd1, 5'd2, 16'd8}, OP_ADD, 3'b001, 4'b0010,
                          1'b1, 4'hF, 1'b0, 5'd0, 32'h1000, 32'hDEAD_BEEF);
    tick();
    chk("sw_addr", 64'(bus.data_sram_addr), 64'h1008);
    chk("sw_wdata", 64'(bus.data_sram_wdata), 64'hDEAD_BEEF);
    chk("sw_en", 64'(bus.data_sram_en), 64'd1);
    chk("sw_wen", 64'(bus.data_sram_wen), 64'hF);

    // slt / sltu / sll / lui
    bus.id_to_ex_bus = mk(32'h4C, rtype(6'b101010), OP_SLT, 3'b001, 4'b0001,
                          1'b0, 4'd0, 1'b1, 5'd3, 32'hFFFF_FFFF, 32'd1);
    tick();
    chk("slt", 64'(bus.ex_to_mem_bus[31:0]), 64'd1);
    bus.id_to_ex_bus = mk(32'h50, rtype(6'b101011), OP_SLTU, 3'b001, 4'b0001,
                          1'b0, 4'd0, 1'b1, 5'd3, 32'hFFFF_FFFF, 32'd1);
    tick();
    chk("sltu", 64'(bus.ex_to_mem_bus[31:0]), 64'd0);
    bus.id_to_ex_bus = mk(32'h54, {6'b0, 5'd0, 5'd2, 5'd3, 5'd4, 6'b0}, OP_SLL, 3'b100, 4'b0001,
                          1'b0, 4'd0, 1'b1, 5'd3, 32'd0, 32'd1);
    tick();
    chk("sll", 64'(bus.ex_to_mem_bus[31:0]), 64'd16);
    bus.id_to_ex_bus = mk(32'h58, {6'b001111, 5'd0, 5'd2, 16'h1234}, OP_LUI, 3'b000, 4'b1000,
                          1'b0, 4'd0, 1'b1, 5'd2, 32'd0, 32'd0);
    tick();
    chk("lui", 64'(bus.ex_to_mem_bus[31:0]), 64'h1234_0000);

    // divides
    run_div("divu_100_7", 6'b011011, 32'd100, 32'd7, 33, 32'd14, 32'd2);
    run_div("div_m7_2", 6'b011010, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_div("div_9_0", 6'b011010, 32'd9, 32'd0, 1, 32'hFFFF_FFFF, 32'd9);

    // multiplies
    bus.id_to_ex_bus = mk(32'h60, rtype(6'b011000), 12'd0, 3'd0, 4'd0, 1'b0, 4'd0, 1'b0, 5'd0,
                          32'hFFFF_FFFF, 32'd2);
    tick();
    mf(6'b010000);
    tick();
    chk("mult_hi", 64'(bus.ex_to_mem_bus[31:0]), 64'hFFFF_FFFF);
    mf(6'b010010);
    tick();
    chk("mult_lo", 64'(bus.ex_to_mem_bus[31:0]), 64'hFFFF_FFFE);
    bus.id_to_ex_bus = mk(32'h64, rtype(6'b011001), 12'd0, 3'd0, 4'd0, 1'b0, 4'd0, 1'b0, 5'd0,
                          32'hFFFF_FFFF, 32'd2);
    tick();
    mf(6'b010000);
    tick();
    chk("multu_hi", 64'(bus.ex_to_mem_bus[31:0]), 64'd1);
    mf(6'b010010);
    tick();
    chk("multu_lo", 64'(bus.ex_to_mem_bus[31:0]), 64'hFFFF_FFFE);

    // mthi
    bus.id_to_ex_bus = mk(32'h68, rtype(6'b010001), 12'd0, 3'd0, 4'd0, 1'b0, 4'd0, 1'b0, 5'd0,
                          32'hCAFE_0001, 32'd0);
    tick();
    mf(6'b010000);
    tick();
    chk("mthi_mfhi", 64'(bus.ex_to_mem_bus[31:0]), 64'hCAFE_0001);

    // reset in the middle of a division
    bus.id_to_ex_bus = mk(32'h6C, rtype(6'b011011), 12'd0, 3'd0, 4'd0, 1'b0, 4'd0, 1'b0, 5'd0,
                          32'd100, 32'd7);
    repeat (5) tick();
    chk("div_busy", 64'(bus.stallreq_for_ex), 64'd1);
    rst = 1'b0;
    #1;
    chk("midrst_stallreq", 64'(bus.stallreq_for_ex), 64'd0);
    tick();
    rst = 1'b1;
    mf(6'b010000);
    tick();
    chk("midrst_hi", 64'(bus.ex_to_mem_bus[31:0]), 64'd0);
    mf(6'b010010);
    tick();
    chk("midrst_lo", 64'(bus.ex_to_mem_bus[31:0]), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
